sd_clk_gen: RTL and testbench
=============================

# sd_clk_gen

Avalon-MM slave generating the SD-card clock pin, replacing the single-bit bit-banged clock output. Keeps a manual (bit-bang) mode for legacy drivers. Adds an automatic mode that emits a programmed number of clock pulses at a programmable divider, so software no longer toggles the pin once per bit. Sits on the system interconnect beside the SD command/data PIOs and drives the SD_CLK pad.

## Interface

- DIV_W, 8, width of divider register; half-period = DIV+1 clk cycles
- CNT_W, 16, width of pulse-count register
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational (read latency 0), unused bits 0
- out_port  out  1  SD clock pin
- busy  out  1  high while an auto burst runs
- irq  out  1  interrupt; present only with SD_CLK_GEN_IRQ_EN

## Operation

- Write = chipselect & ~write_n; read = chipselect & ~read_n.
- addr 0 LEVEL: bit0 manual level. Write always stored; drives out_port only when CTRL.mode=0. Reads return current out_port.
- addr 1 DIV: DIV_W bits. Writes while busy ignored. Reset = all ones.
- addr 2 COUNT: write with mode=1, not busy, value≠0 starts burst of COUNT pulses. Write of 0, write while busy, or write with mode=0 ignored. Read returns remaining pulses (0 when idle).
- addr 3 CTRL: bit0 mode (0 manual, 1 auto), bit1 idle_level, bit2 done (sticky, write 1 clears), bit3 busy (RO), bit4 irq_en (only with macro, else reads 0). Reset all 0.
- FSM: IDLE, PH_LOW, PH_HIGH. Half-period counter hc counts 0..DIV.
  - IDLE: out_port = LEVEL.bit0 (mode 0) or idle_level (mode 1). Valid start -> PH_LOW, hc=0.
  - PH_LOW: out_port=0; hc==DIV -> PH_HIGH, hc=0.
  - PH_HIGH: out_port=1; hc==DIV -> decrement remaining; if it becomes 0 -> IDLE, set done; else -> PH_LOW.
- out_port is registered (glitch-free).
- Writing mode=0 while busy aborts: -> IDLE next cycle, remaining=0, done not set, out_port = LEVEL.bit0.
- done set and write-1-clear same cycle: set wins.

## Timing

- Reset: out_port=0, busy=0, irq=0, LEVEL=0, CTRL=0, remaining=0, state IDLE, DIV all ones.
- Start write sampled at edge T: busy=1 and out_port=0 from T+1.
- First rising edge of out_port at T+1+(DIV+1); pulse k rises at T+1+(2k-1)(DIV+1).
- Burst ends at T+1+2N(DIV+1): busy=0, done=1, out_port=idle_level same cycle.
- DIV=0: out_port toggles every clk (clk/2).
- Back-to-back bursts: new COUNT write accepted first cycle busy=0.
- Reset asserted mid-burst: all outputs to reset values immediately (async), burst lost.

## Configuration

- SD_CLK_GEN_IRQ_EN defined: irq port and CTRL.bit4 exist; irq = done & irq_en, registered; cleared by clearing done or irq_en.
- Not defined: no irq port, CTRL.bit4 reads 0 and ignores writes; otherwise identical.

## Test plan

- Reset: reset_n low mid-burst (DIV=3, COUNT=5) -> out_port=0, busy=0, readdata@3 = 0, DIV reads 0xFF.
- Manual mode: write LEVEL=1 -> out_port=1 next cycle; write LEVEL=0 -> 0; COUNT=4 write ignored, busy stays 0.
- Auto burst: mode=1, idle_level=1, DIV=2, COUNT=3 -> out_port low 3/high 3 cycles ×3, busy 18 cycles, then done=1, out_port=1.
- DIV=0, COUNT=1 -> out_port 0 one cycle, 1 one cycle, busy=2 cycles; DIV/COUNT writes during busy ignored (readback unchanged).
- Abort: mode=1, DIV=4, COUNT=10, after 12 cycles write CTRL mode=0 -> next cycle busy=0, done=0, COUNT reads 0, out_port=LEVEL.
- IRQ (macro on): irq_en=1, COUNT=2, DIV=1 -> irq=1 one cycle after done; write CTRL done=1 -> irq=0; simultaneous set/clear keeps done=1.

Source files
------------

// File: rtl/sd_clk_gen.sv
// -----------------------------------------------------------------------------
// sd_clk_gen -- Avalon-MM slave that drives the SD_CLK pad.
//
// Two modes:
//   manual (CTRL.mode=0): out_port follows the LEVEL register (bit-bang).
//   auto   (CTRL.mode=1): a COUNT write emits COUNT clock pulses, each pulse
//                         being DIV+1 clk cycles low then DIV+1 cycles high.
//
// Register map (address):
//   0 LEVEL : bit0 manual level (read returns current out_port)
//   1 DIV   : half-period minus one, DIV_W bits, reset all ones
//   2 COUNT : write starts a burst, read returns remaining pulses
//   3 CTRL  : bit0 mode, bit1 idle_level, bit2 done (W1C), bit3 busy (RO),
//             bit4 irq_en (only when SD_CLK_GEN_IRQ_EN is defined)
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   address/chipselect/write_n/read_n/writedata/readdata  Avalon-MM slave,
//                                 readdata combinational (read latency 0)
//   out_port                      registered SD clock pin
//   busy                          high while an auto burst runs
//   irq                           done & irq_en, registered
//                                 (port exists only with SD_CLK_GEN_IRQ_EN)
//
// Optional feature macro: SD_CLK_GEN_IRQ_EN
// -----------------------------------------------------------------------------
module sd_clk_gen #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic        read_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        out_port,
   output logic        busy
`ifdef SD_CLK_GEN_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam logic [1:0] ADDR_LEVEL = 2'd0;
   localparam logic [1:0] ADDR_DIV   = 2'd1;
   localparam logic [1:0] ADDR_COUNT = 2'd2;
   localparam logic [1:0] ADDR_CTRL  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PH_LOW  = 2'd1,
      ST_PH_HIGH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   hc_q, hc_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic               level_q, level_d;
   logic               mode_q, mode_d;
   logic               idle_level_q, idle_level_d;
   logic               done_q, done_d;
   logic               out_q, out_d;
   logic               irq_en_bit;

   logic               wr_en;
   logic               rd_en;
   logic               ctrl_wr;
   logic               done_set;
   logic               start;
   logic               abort;

   // Only the low bits of writedata carry register fields.
   logic               unused_wd;
   assign unused_wd = ^writedata;

   assign wr_en   = chipselect & ~write_n;
   assign rd_en   = chipselect & ~read_n;
   assign ctrl_wr = wr_en && (address == ADDR_CTRL);

   // A burst starts only from IDLE, in auto mode, with a non-zero count.
   assign start = wr_en && (address == ADDR_COUNT) && mode_q &&
                  (state_q == ST_IDLE) && (writedata[CNT_W-1:0] != '0);

   // Dropping back to manual mode while a burst runs cancels it.
   assign abort = ctrl_wr && !writedata[0] && (state_q != ST_IDLE);

`ifdef SD_CLK_GEN_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q, irq_d;

   always_comb begin
      irq_en_d = irq_en_q;
      if (ctrl_wr) begin
         irq_en_d = writedata[4];
      end
      irq_d = done_q & irq_en_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq        = irq_q;
   assign irq_en_bit = irq_en_q;
`else
   assign irq_en_bit = 1'b0;
`endif

   // Register writes, FSM next state and the registered pin value.
   always_comb begin
      state_d      = state_q;
      hc_d         = hc_q;
      div_d        = div_q;
      remaining_d  = remaining_q;
      level_d      = level_q;
      mode_d       = mode_q;
      idle_level_d = idle_level_q;
      done_d       = done_q;
      done_set     = 1'b0;
      out_d        = out_q;

      if (wr_en && (address == ADDR_LEVEL)) begin
         level_d = writedata[0];
      end
      if (wr_en && (address == ADDR_DIV) && (state_q == ST_IDLE)) begin
         div_d = writedata[DIV_W-1:0];
      end
      if (ctrl_wr) begin
         mode_d       = writedata[0];
         idle_level_d = writedata[1];
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_PH_LOW;
               hc_d        = '0;
               remaining_d = writedata[CNT_W-1:0];
            end
         end
         ST_PH_LOW: begin
            if (hc_q == div_q) begin
               state_d = ST_PH_HIGH;
               hc_d    = '0;
            end else begin
               hc_d = hc_q + DIV_W'(1);
            end
         end
         ST_PH_HIGH: begin
            if (hc_q == div_q) begin
               hc_d        = '0;
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  state_d  = ST_IDLE;
                  done_set = 1'b1;
               end else begin
                  state_d = ST_PH_LOW;
               end
            end else begin
               hc_d = hc_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            hc_d    = '0;
         end
      endcase

      // Abort overrides the burst progress, including a completion that
      // happens to land on the same edge: an aborted burst never sets done.
      if (abort) begin
         state_d     = ST_IDLE;
         hc_d        = '0;
         remaining_d = '0;
         done_set    = 1'b0;
      end

      // A hardware set beats a simultaneous software clear.
      if (done_set) begin
         done_d = 1'b1;
      end else if (ctrl_wr && writedata[2]) begin
         done_d = 1'b0;
      end

      // The pin is decoded from next-state values so it changes exactly on
      // the same edge as the state, without any combinational path to the pad.
      unique case (state_d)
         ST_PH_LOW:  out_d = 1'b0;
         ST_PH_HIGH: out_d = 1'b1;
         default:    out_d = mode_d ? idle_level_d : level_d;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         hc_q         <= '0;
         div_q        <= '1;
         remaining_q  <= '0;
         level_q      <= 1'b0;
         mode_q       <= 1'b0;
         idle_level_q <= 1'b0;
         done_q       <= 1'b0;
         out_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hc_q         <= hc_d;
         div_q        <= div_d;
         remaining_q  <= remaining_d;
         level_q      <= level_d;
         mode_q       <= mode_d;
         idle_level_q <= idle_level_d;
         done_q       <= done_d;
         out_q        <= out_d;
      end
   end

   assign out_port = out_q;
   assign busy     = (state_q != ST_IDLE);

   always_comb begin
      readdata = '0;
      if (rd_en) begin
         unique case (address)
            ADDR_LEVEL: readdata = {31'd0, out_q};
            ADDR_DIV:   readdata = 32'(div_q);
            ADDR_COUNT: readdata = 32'(remaining_q);
            ADDR_CTRL:  readdata = {27'd0, irq_en_bit, busy, done_q,
                                    idle_level_q, mode_q};
            default:    readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_sd_clk_gen -- directed self-checking bench for sd_clk_gen.
// Expected values are queued when stimulus is applied and popped in order
// when the corresponding DUT output is sampled (1 ns after the rising edge).
// -----------------------------------------------------------------------------
module tb_sd_clk_gen;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        out_port;
   logic        busy;
`ifdef SD_CLK_GEN_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   sd_clk_gen #(.DIV_W(8), .CNT_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .read_n     (read_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .busy       (busy)
`ifdef SD_CLK_GEN_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   task automatic expect_val(input string tag, input logic [31:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL sb_underflow: observed 0x%08h, nothing expected", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", t, obs, e);
         end
         $display("check %-20s observed 0x%08h expected 0x%08h", t, obs, e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cyc();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      address    = a;
      chipselect = 1'b1;
      read_n     = 1'b0;
      #1;
      v          = readdata;
      chipselect = 1'b0;
      read_n     = 1'b1;
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      read_n     = 1'b1;
      writedata  = '0;

      // ---- reset state ----
      #12;
      expect_val("rst_out", 0);     chk(out_port);
      expect_val("rst_busy", 0);    chk(busy);
      expect_val("rst_div", 32'hFF); rd(2'd1, v); chk(v);
      expect_val("rst_ctrl", 0);    rd(2'd3, v); chk(v);
      expect_val("rst_count", 0);   rd(2'd2, v); chk(v);
      cyc();
      reset_n = 1'b1;
      cyc();

      // ---- manual mode ----
      wr(2'd0, 32'd1);
      expect_val("man_out_hi", 1);  chk(out_port);
      expect_val("man_level_rd", 1); rd(2'd0, v); chk(v);
      wr(2'd0, 32'd0);
      expect_val("man_out_lo", 0);  chk(out_port);
      wr(2'd2, 32'd4);
      expect_val("man_cnt_busy", 0); chk(busy);
      expect_val("man_cnt_rd", 0);  rd(2'd2, v); chk(v);

      // ---- auto burst: DIV=2, COUNT=3, idle_level=1 ----
      wr(2'd3, 32'h3);
      expect_val("auto_idle_out", 1); chk(out_port);
      wr(2'd1, 32'd2);
      expect_val("auto_ctrl", 32'h3); rd(2'd3, v); chk(v);
      for (int i = 0; i < 18; i++) begin
         expect_val($sformatf("burst_out[%0d]", i), 32'((i / 3) % 2));
         expect_val($sformatf("burst_busy[%0d]", i), 1);
      end
      wr(2'd2, 32'd3);
      for (int i = 0; i < 18; i++) begin
         chk(out_port);
         chk(busy);
         cyc();
      end
      expect_val("burst_end_busy", 0); chk(busy);
      expect_val("burst_end_out", 1);  chk(out_port);
      expect_val("burst_end_ctrl", 32'h7); rd(2'd3, v); chk(v);
      expect_val("burst_end_cnt", 0);  rd(2'd2, v); chk(v);

      // ---- DIV=0, COUNT=1 with writes during busy ----
      wr(2'd1, 32'd0);
      wr(2'd2, 32'd1);
      expect_val("d0_out0", 0);  chk(out_port);
      expect_val("d0_busy0", 1); chk(busy);
      wr(2'd1, 32'd5);
      expect_val("d0_out1", 1);  chk(out_port);
      expect_val("d0_busy1", 1); chk(busy);
      wr(2'd2, 32'd7);
      expect_val("d0_busy2", 0); chk(busy);
      expect_val("d0_out2", 1);  chk(out_port);
      expect_val("d0_div_rd", 0); rd(2'd1, v); chk(v);
      expect_val("d0_cnt_rd", 0); rd(2'd2, v); chk(v);

      // ---- abort: DIV=4, COUNT=10 ----
      wr(2'd3, 32'h5);
      expect_val("ab_ctrl", 32'h1); rd(2'd3, v); chk(v);
      expect_val("ab_idle_out", 0); chk(out_port);
      wr(2'd0, 32'd1);
      expect_val("ab_level_held", 0); chk(out_port);
      wr(2'd1, 32'd4);
      wr(2'd2, 32'd10);
      expect_val("ab_busy", 1); chk(busy);
      repeat (11) cyc();
      expect_val("ab_remaining", 9); rd(2'd2, v); chk(v);
      wr(2'd3, 32'h0);
      expect_val("ab_busy_after", 0); chk(busy);
      expect_val("ab_out_level", 1);  chk(out_port);
      expect_val("ab_ctrl_after", 0); rd(2'd3, v); chk(v);
      expect_val("ab_cnt_after", 0);  rd(2'd2, v); chk(v);
      wr(2'd0, 32'd0);
      expect_val("ab_man_lo", 0); chk(out_port);

      // ---- done set and W1C on the same edge ----
      wr(2'd3, 32'h1);
      wr(2'd1, 32'd0);
      wr(2'd2, 32'd1);
      cyc();
      wr(2'd3, 32'h5);
      expect_val("col_ctrl", 32'h5); rd(2'd3, v); chk(v);
      wr(2'd3, 32'h5);
      expect_val("col_cleared", 32'h1); rd(2'd3, v); chk(v);

`ifdef SD_CLK_GEN_IRQ_EN
      // ---- interrupt ----
      wr(2'd3, 32'h11);
      wr(2'd1, 32'd1);
      wr(2'd2, 32'd2);
      repeat (8) cyc();
      expect_val("irq_done_ctrl", 32'h15); rd(2'd3, v); chk(v);
      expect_val("irq_not_yet", 0); chk(irq);
      cyc();
      expect_val("irq_set", 1); chk(irq);
      wr(2'd3, 32'h15);
      cyc();
      expect_val("irq_clr", 0); chk(irq);
      expect_val("irq_ctrl_clr", 32'h11); rd(2'd3, v); chk(v);
`endif

      // ---- reset mid-burst: DIV=3, COUNT=5 ----
      wr(2'd3, 32'h1);
      wr(2'd1, 32'd3);
      wr(2'd2, 32'd5);
      repeat (7) cyc();
      expect_val("mr_busy_pre", 1); chk(busy);
      expect_val("mr_out_pre", 1);  chk(out_port);
      #2;
      reset_n = 1'b0;
      #1;
      expect_val("mr_out", 0);     chk(out_port);
      expect_val("mr_busy", 0);    chk(busy);
      expect_val("mr_ctrl", 0);    rd(2'd3, v); chk(v);
      expect_val("mr_div", 32'hFF); rd(2'd1, v); chk(v);
      expect_val("mr_cnt", 0);     rd(2'd2, v); chk(v);
`ifdef SD_CLK_GEN_IRQ_EN
      expect_val("mr_irq", 0);     chk(irq);
`endif
      cyc();
      reset_n = 1'b1;
      cyc();

      n_cmp++;
      assert (exp_q.size() == 0) else begin
         n_err++;
         $error("FAIL sb_leftover: observed %0d pending expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
